// File: rtl/uart_rx_if.sv
// uart_rx_if: picorv32-style memory bus between the CPU side (master) and the
// UART receiver peripheral (slave). The decoder select `enable` travels with
// the bus so the peripheral sees one bundle.
interface uart_rx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped UART receiver (base 0xffff0050).
// Synchronizes the RX pin, frames characters with a down-counting bit timer,
// buffers bytes in a FIFO and serves two bus registers:
//   addr[2]=0 : RX data   {23'b0, valid, byte}, a read pops one entry
//   addr[2]=1 : status    {27'b0, perr, ferr, ovr, full, !empty}
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and a live
// perr bit; without it frames are 8N1 and perr reads 0.
module uart_rx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus,
    input  logic       serialIn
);

    localparam int          DIV_INT  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [15:0] DIV_HALF = 16'(DIV_INT / 2);
    // Reloading with DIV-1 makes the timer hit zero exactly every DIV clocks.
    localparam logic [15:0] DIV_M1   = 16'(DIV_INT - 1);
    localparam int          AW       = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Expected parity bit for even parity over the data byte.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    // Registers and their next-state values
    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shift_q, shift_d;
    logic          fperr_q, fperr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    // Combinational helpers
    logic          rx_s;
    logic          tick_s;
    logic          push_s;
    logic          push_ok_s;
    logic          pop_s;
    logic          ferr_set_s;
    logic          perr_set_s;
    logic          ovr_set_s;
    logic          empty_s;
    logic          full_s;
    logic          start_s;
    logic          is_wr_s;
    logic          sel_stat_s;
    logic [4:0]    clr_s;
    logic [31:0]   status_s;
    logic [7:0]    head_s;
    logic          unused_s;

    assign rx_s       = sync2_q;
    assign tick_s     = (cnt_q == 16'd0);
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_s     = fifo_mem[rd_ptr_q[AW-1:0]];
    assign status_s   = {27'd0, perr_q, ferr_q, ovr_q, full_s, !empty_s};
    assign start_s    = bus.enable && bus.mem_valid && !ready_q;
    assign is_wr_s    = (bus.mem_wstrb != 4'd0);
    assign sel_stat_s = bus.mem_addr[2];

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

`ifdef UART_RX_PARITY_EN
    assign unused_s = ^{bus.mem_instr, bus.mem_addr[31:3], bus.mem_addr[1:0],
                        bus.mem_wdata[31:5], bus.mem_wstrb[3:1]};
`else
    assign unused_s = ^{bus.mem_instr, bus.mem_addr[31:3], bus.mem_addr[1:0],
                        bus.mem_wdata[31:4], bus.mem_wstrb[3:1]};
`endif

    // Receiver next-state: bit timing, shifting, error detection and push request
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitn_d     = bitn_q;
        shift_d    = shift_q;
        fperr_d    = fperr_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        perr_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = DIV_HALF;
                end else begin
                    cnt_d   = 16'd0;
                end
            end
            S_START: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s) begin
                    state_d = S_DATA;
                    cnt_d   = DIV_M1;
                    bitn_d  = 3'd0;
                    fperr_d = 1'b0;
                end else begin
                    // Line went back high before mid-start: a glitch
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = DIV_M1;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d   = DIV_M1;
                    state_d = S_STOP;
                    if (rx_s != even_parity(shift_q)) begin
                        fperr_d    = 1'b1;
                        perr_set_s = 1'b1;
                    end else begin
                        fperr_d    = 1'b0;
                    end
                end
            end
`endif
            S_STOP: begin
                if (!tick_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s) begin
                    push_s  = !fperr_q;
                    state_d = S_IDLE;
                end else begin
                    ferr_set_s = 1'b1;
                    state_d    = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus decode, FIFO pointer update and sticky status bits
    always_comb begin
        pop_s     = 1'b0;
        clr_s     = 5'd0;
        ready_d   = 1'b0;
        rdata_d   = 32'd0;
        if (start_s) begin
            ready_d = 1'b1;
            if (is_wr_s) begin
                if (sel_stat_s && bus.mem_wstrb[0]) begin
                    clr_s = bus.mem_wdata[4:0];
                end else begin
                    clr_s = 5'd0;
                end
            end else if (sel_stat_s) begin
                rdata_d = status_s;
            end else if (!empty_s) begin
                rdata_d = {23'd0, 1'b1, head_s};
                pop_s   = 1'b1;
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            ready_d = 1'b0;
        end

        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
        push_ok_s = push_s && (!full_s || pop_s);
        ovr_set_s = push_s && full_s && !pop_s;
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_ok_s};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop_s};

        // Set events override a clear in the same cycle
        ovr_d  = (ovr_q  & ~clr_s[2]) | ovr_set_s;
        ferr_d = (ferr_q & ~clr_s[3]) | ferr_set_s;
`ifdef UART_RX_PARITY_EN
        perr_d = (perr_q & ~clr_s[4]) | perr_set_s;
`else
        perr_d = 1'b0;
`endif
    end

    // State register for synchronizer, receiver FSM, FIFO pointers, status and bus response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bitn_q   <= 3'd0;
            shift_q  <= 8'd0;
            fperr_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            sync1_q  <= serialIn;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitn_q   <= bitn_d;
            shift_q  <= shift_d;
            fperr_q  <= fperr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Serial frames are generated
// bit by bit; every good byte sent is pushed to a scoreboard queue and
// compared when the CPU reads the RX data register.
module tb_uart_rx;

    localparam int CLK_HZ     = 1600000;
    localparam int BAUD       = 100000;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV        = (CLK_HZ + BAUD / 2) / BAUD;   // 16
    localparam logic [31:0] A_DATA = 32'hffff0050;
    localparam logic [31:0] A_STAT = 32'hffff0054;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic rx_line;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q [$];
    logic [31:0] rd;

    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .serialIn (rx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transfer; checks single-cycle acknowledge and idle rdata afterwards
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int cyc;
        bit got;
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
        got   = 1'b0;
        cyc   = 0;
        rdata = 32'hdeadbeef;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_ready) begin
                got   = 1'b1;
                rdata = bus.mem_rdata;
            end
        end
        check_eq("ack_seen", {31'd0, got}, 32'd1);
        // Request still held: ready must not reassert
        @(posedge clk);
        #1;
        check_eq("ready_once", {31'd0, bus.mem_ready}, 32'd0);
        check_eq("rdata_idle", bus.mem_rdata, 32'd0);
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'd0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rdata);
        bus_xfer(addr, 4'd0, 32'd0, rdata);
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_xfer(addr, 4'hf, wdata, dummy);
    endtask

    // Read RX data and compare with the scoreboard head (0 when nothing expected)
    task automatic read_check(input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        bus_rd(A_DATA, got);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        check_eq(tag, got, exp);
    endtask

    task automatic bit_time(input logic v);
        rx_line = v;
        repeat (DIV) @(negedge clk);
    endtask

    // Raw frame: start, 8 data LSB first, optional parity bit, stop; line left at stop level
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (PAR_EN) bit_time(par_v);
        bit_time(stop_v);
    endtask

    // Good frame plus one idle bit
    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
        bit_time(1'b1);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rx_line       = 1'b1;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wstrb = 4'd0;
        bus.mem_wdata = 32'd0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
        check_eq("reset_rdata", bus.mem_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Idle line status
        bus_rd(A_STAT, rd);
        check_eq("idle_status", rd, 32'd0);

        // Single byte, then empty read
        send_byte(8'h55);
        exp_q.push_back(32'h155);
        read_check("byte_55");
        read_check("empty_read");

        // Overrun: 17 bytes, the last one dropped
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            send_byte(8'(i));
            if (i < FIFO_DEPTH) exp_q.push_back(32'h100 | 32'(i));
        end
        bus_rd(A_STAT, rd);
        check_eq("ovr_status", rd, 32'h7);
        for (int i = 0; i < FIFO_DEPTH; i++) read_check("ovr_data");
        read_check("ovr_drained");
        bus_wr(A_STAT, 32'h4);
        bus_rd(A_STAT, rd);
        check_eq("ovr_cleared", rd, 32'h0);

        // Framing error: stop bit 0, line held low three bit times in total
        send_frame(8'h5a, 1'b0, ^(8'h5a));
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        bus_rd(A_STAT, rd);
        check_eq("ferr_status", rd, 32'h8);
        send_byte(8'ha3);
        exp_q.push_back(32'h1a3);
        read_check("after_break");
        bus_wr(A_STAT, 32'h8);
        bus_rd(A_STAT, rd);
        check_eq("ferr_cleared", rd, 32'h0);

        // Glitch of DIV/4 clocks must be rejected
        rx_line = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        bus_rd(A_STAT, rd);
        check_eq("glitch_status", rd, 32'h0);
        send_byte(8'h3c);
        exp_q.push_back(32'h13c);
        read_check("after_glitch");

        // Reset mid-frame empties the FIFO and aborts the frame
        send_byte(8'h11);
        fork
            send_byte(8'hf0);
            begin
                repeat (5 * DIV) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        bit_time(1'b1);
        bus_rd(A_STAT, rd);
        check_eq("reset_midframe", rd, 32'h0);
        send_byte(8'h96);
        exp_q.push_back(32'h196);
        read_check("after_reset");

`ifdef UART_RX_PARITY_EN
        // Parity: 0x01 with parity 0 is bad, 0x03 with parity 0 is good
        send_frame(8'h01, 1'b1, 1'b0);
        bit_time(1'b1);
        bus_rd(A_STAT, rd);
        check_eq("perr_status", rd, 32'h10);
        send_frame(8'h03, 1'b1, 1'b0);
        bit_time(1'b1);
        exp_q.push_back(32'h103);
        read_check("parity_good");
        bus_wr(A_STAT, 32'h10);
        bus_rd(A_STAT, rd);
        check_eq("perr_cleared", rd, 32'h0);
`else
        // perr is not built: writing its clear bit changes nothing
        bus_wr(A_STAT, 32'h10);
        bus_rd(A_STAT, rd);
        check_eq("perr_absent", rd, 32'h0);
`endif

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
